// File: rtl/hack_boot_sequencer_pkg.sv
// Shared types and constants for the Hack boot sequencer: state encoding,
// byte/word widths and the byte-accepting state set.
package hack_boot_sequencer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    // Image header order: length high byte first, then low byte; words likewise hi then lo.
    typedef enum logic [3:0] {
        S_LEN_HI = 4'd0,
        S_LEN_LO = 4'd1,
        S_DAT_HI = 4'd2,
        S_DAT_LO = 4'd3,
        S_CK_HI  = 4'd4,
        S_CK_LO  = 4'd5,
        S_HOLD   = 4'd6,
        S_RUN    = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    function automatic logic rx_ready_state(input state_t s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CK_HI, S_CK_LO};
    endfunction

endpackage

// File: rtl/hack_word_assembler.sv
// Builds a 16-bit word from a latched high byte and the current low byte;
// shared by the length, data and checksum paths of the boot sequencer.
module hack_word_assembler
    import hack_boot_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_hi_we,
    input  logic              i_lo_we,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_c,
    output logic              o_word_valid_c
);

    logic [BYTE_W-1:0] r_hi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
        end else if (i_hi_we) begin
            r_hi <= i_byte;
        end
    end

    assign o_word_c       = {r_hi, i_byte};
    assign o_word_valid_c = i_lo_we;

endmodule

// File: rtl/hack_boot_sequencer.sv
// Boot controller: streams a length-prefixed image into instruction ROM, then
// releases CPU reset after a fixed hold. HACK_BOOT_CHECKSUM_EN adds a trailing checksum.
module hack_boot_sequencer
    import hack_boot_sequencer_pkg::*;
#(
    parameter int unsigned AW       = 15,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    output logic              rom_we,
    output logic [AW-1:0]     rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_reset,
    output logic              loaded,
    output logic              error,
    output logic [AW:0]       words_loaded
);

    localparam int unsigned DEPTH = 32'd1 << AW;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned HW    = $clog2(HOLD_CYC + 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_rx_ready;
    logic              r_rom_we;
    logic [AW-1:0]     r_rom_addr;
    logic [WORD_W-1:0] r_rom_wdata;
    logic              r_cpu_reset;
    logic              r_loaded;
    logic              r_error;
    logic [CW-1:0]     r_words;
    logic [CW-1:0]     r_len;
    logic [HW-1:0]     r_hold;

    logic              w_accept;
    logic              w_hi_we;
    logic              w_lo_we;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic              w_word_we;
    logic              w_last;
    logic              w_len_big;
    logic              w_enter_hold;
    logic              w_restart_load;

    assign w_accept  = rx_valid & r_rx_ready;
    assign w_hi_we   = w_accept & (r_state inside {S_LEN_HI, S_DAT_HI, S_CK_HI});
    assign w_lo_we   = w_accept & (r_state inside {S_LEN_LO, S_DAT_LO, S_CK_LO});
    assign w_word_we = w_word_valid & (r_state == S_DAT_LO);
    assign w_last    = (r_words + CW'(1)) == r_len;
    assign w_len_big = 32'(w_word) > DEPTH;

    hack_word_assembler u_asm (
        .clock          (clock),
        .reset          (reset),
        .i_hi_we        (w_hi_we),
        .i_lo_we        (w_lo_we),
        .i_byte         (rx_data),
        .o_word_c       (w_word),
        .o_word_valid_c (w_word_valid)
    );

`ifdef HACK_BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_restart_load) begin
            r_sum <= '0;
        end else if (w_word_we) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_LEN_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_word_valid) begin
                    if (w_len_big)           w_next = S_ERR;
                    else if (w_word == '0)   w_next = S_HOLD;
                    else                     w_next = S_DAT_HI;
                end
            end
            S_DAT_HI: if (w_accept) w_next = S_DAT_LO;
            S_DAT_LO: begin
                if (w_word_valid) begin
`ifdef HACK_BOOT_CHECKSUM_EN
                    w_next = w_last ? S_CK_HI : S_DAT_HI;
`else
                    w_next = w_last ? S_HOLD : S_DAT_HI;
`endif
                end
            end
`ifdef HACK_BOOT_CHECKSUM_EN
            S_CK_HI: if (w_accept) w_next = S_CK_LO;
            S_CK_LO: if (w_word_valid) w_next = (w_word == r_sum) ? S_HOLD : S_ERR;
`endif
            S_HOLD:  if (r_hold == '0) w_next = S_RUN;
            S_RUN,
            S_ERR:   if (restart) w_next = S_LEN_HI;
            default: w_next = S_LEN_HI;
        endcase
    end

    assign w_enter_hold   = (w_next == S_HOLD) && (r_state != S_HOLD);
    assign w_restart_load = (w_next == S_LEN_HI) && (r_state != S_LEN_HI);

    // Data entry waits one extra cycle so the count starts after the final write cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_ready  <= 1'b0;
            r_rom_we    <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_loaded    <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
            r_len       <= '0;
            r_hold      <= '0;
        end else begin
            r_rx_ready  <= rx_ready_state(w_next);
            r_cpu_reset <= (w_next != S_RUN);
            r_loaded    <= (w_next == S_RUN);
            r_error     <= (w_next == S_ERR);
            r_rom_we    <= w_word_we;
            if (w_word_we) begin
                r_rom_addr  <= r_words[AW-1:0];
                r_rom_wdata <= w_word;
            end
            if (w_restart_load) begin
                r_words <= '0;
            end else if (w_word_we) begin
                r_words <= r_words + CW'(1);
            end
            if (w_word_valid && (r_state == S_LEN_LO)) begin
                r_len <= CW'(w_word);
            end
            if (w_enter_hold) begin
                r_hold <= (r_state == S_DAT_LO) ? HW'(HOLD_CYC) : HW'(HOLD_CYC - 1);
            end else if ((r_state == S_HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - HW'(1);
            end
        end
    end

    assign rx_ready     = r_rx_ready;
    assign rom_we       = r_rom_we;
    assign rom_addr     = r_rom_addr;
    assign rom_wdata    = r_rom_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign loaded       = r_loaded;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Testbench for hack_boot_sequencer: directed and randomized image loads checked
// against an image-level reference model of writes, timing and final status.
module tb_hack_boot_sequencer;

    localparam int unsigned AW       = 15;
    localparam int unsigned HOLD_CYC = 4;
`ifdef HACK_BOOT_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          restart;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_reset;
    logic          loaded;
    logic          error;
    logic [AW:0]   words_loaded;

    hack_boot_sequencer #(.AW(AW), .HOLD_CYC(HOLD_CYC)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .restart      (restart),
        .rom_we       (rom_we),
        .rom_addr     (rom_addr),
        .rom_wdata    (rom_wdata),
        .cpu_reset    (cpu_reset),
        .loaded       (loaded),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    bit          tog = 1'b0;
    logic        prev_cr = 1'b1;
    logic [15:0] img[$];
    int          wq_addr[$];
    int          wq_data[$];
    int          wq_cyc[$];
    int          fall_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Observed ROM writes and cpu_reset falling edges, stamped with the edge count.
    always @(negedge clock) begin
        if (!reset && rom_we) begin
            wq_addr.push_back(int'(rom_addr));
            wq_data.push_back(int'(rom_wdata));
            wq_cyc.push_back(cyc);
        end
        if (prev_cr === 1'b1 && cpu_reset === 1'b0) fall_q.push_back(cyc);
        prev_cr <= cpu_reset;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode, output int acc_cyc);
        bit v;
        bit r;
        int guard;
        guard = 0;
        do begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            rx_valid = v;
            rx_data  = b;
            if (mode == 2) restart = 1'($urandom_range(0, 1));
            r = rx_ready;
            tick();
            guard++;
        end while (!(v && r) && guard < 100);
        rx_valid = 1'b0;
        restart  = 1'b0;
        acc_cyc  = cyc;
        if (!(v && r)) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] img_sum(input int n);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < n && i < img.size(); i++) s = s + img[i];
        return s;
    endfunction

    task automatic run_image(input string nm, input int n, input logic [15:0] ck, input int mode);
        int   acc;
        int   lenlo_cyc;
        int   ck_cyc;
        int   g;
        int   lo_cyc[$];
        bit   big;
        bit   ck_sent;
        bit   exp_err;
        int   exp_nw;
        int   exp_fall;
        int   got;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); fall_q.delete();
        big     = (n > (1 << AW));
        ck_sent = 1'b0;
        ck_cyc  = 0;
        send_byte(8'(n >> 8), mode, acc);
        send_byte(8'(n), mode, lenlo_cyc);
        if (!big) begin
            for (int i = 0; i < n; i++) begin
                send_byte(img[i][15:8], mode, acc);
                send_byte(img[i][7:0], mode, acc);
                lo_cyc.push_back(acc);
            end
            if (CK_EN && n > 0) begin
                send_byte(ck[15:8], mode, acc);
                send_byte(ck[7:0], mode, ck_cyc);
                ck_sent = 1'b1;
            end
        end
        check({nm, "_rx_ready_after_last"}, 32'(rx_ready), 32'd0);
        g = 0;
        while (!(loaded || error) && g < 40) begin
            tick();
            g++;
        end
        exp_err = big || (ck_sent && ck != img_sum(n));
        exp_nw  = big ? 0 : n;
        check({nm, "_done"}, 32'(loaded | error), 32'd1);
        check({nm, "_nwrites"}, 32'(wq_addr.size()), 32'(exp_nw));
        for (int i = 0; i < exp_nw; i++) begin
            got = (i < wq_addr.size()) ? wq_addr[i] : -1;
            check($sformatf("%s_addr%0d", nm, i), 32'(got), 32'(i));
            got = (i < wq_data.size()) ? wq_data[i] : -1;
            check($sformatf("%s_data%0d", nm, i), 32'(got), 32'(img[i]));
            got = (i < wq_cyc.size()) ? wq_cyc[i] : -1;
            check($sformatf("%s_we_cyc%0d", nm, i), 32'(got), 32'(lo_cyc[i]));
        end
        check({nm, "_words_loaded"}, 32'(words_loaded), 32'(exp_nw));
        check({nm, "_error"}, 32'(error), 32'(exp_err));
        check({nm, "_loaded"}, 32'(loaded), 32'(!exp_err));
        check({nm, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_err));
        check({nm, "_rx_ready_idle"}, 32'(rx_ready), 32'd0);
        if (exp_err) exp_fall = -1;
        else if (ck_sent) exp_fall = ck_cyc + HOLD_CYC;
        else if (n == 0) exp_fall = lenlo_cyc + HOLD_CYC;
        else exp_fall = lo_cyc[n-1] + 1 + HOLD_CYC;
        got = (fall_q.size() > 0) ? fall_q[0] : -1;
        check({nm, "_release_cyc"}, 32'(got), 32'(exp_fall));
        // A byte offered while not ready must be left alone.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        tick();
        tick();
        rx_valid = 1'b0;
        check({nm, "_held_byte_no_write"}, 32'(wq_addr.size()), 32'(exp_nw));
        check({nm, "_held_words"}, 32'(words_loaded), 32'(exp_nw));
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check({nm, "_rs_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({nm, "_rs_loaded"}, 32'(loaded), 32'd0);
        check({nm, "_rs_error"}, 32'(error), 32'd0);
        check({nm, "_rs_rx_ready"}, 32'(rx_ready), 32'd1);
        check({nm, "_rs_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int acc;
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        restart  = 1'b0;
        tick();
        tick();
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_rom_we", 32'(rom_we), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        tick();
        check("rel_rx_ready", 32'(rx_ready), 32'd1);

        img = '{16'h0002, 16'hEC10, 16'hE308};
        run_image("sum_head", 3, img_sum(3), 0);
        run_image("sum_toggle", 3, img_sum(3), 1);

        img.delete();
        run_image("empty", 0, 16'h0000, 0);
        run_image("oversize", 32'h8001, 16'h0000, 2);

        // Largest legal length is accepted and the load begins.
        send_byte(8'h80, 0, acc);
        send_byte(8'h00, 0, acc);
        check("max_len_error", 32'(error), 32'd0);
        check("max_len_rx_ready", 32'(rx_ready), 32'd1);
        check("max_len_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        img.delete();
        for (int i = 0; i < 5; i++) img.push_back(16'($urandom));
        send_byte(8'h00, 0, acc);
        send_byte(8'h05, 0, acc);
        for (int i = 0; i < 2; i++) begin
            send_byte(img[i][15:8], 0, acc);
            send_byte(img[i][7:0], 0, acc);
        end
        check("midrst_we_before", 32'(rom_we), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_rom_we", 32'(rom_we), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_words", 32'(words_loaded), 32'd0);
        img = '{16'h1234};
        run_image("reload", 1, 16'h1234, 0);

        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 8);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(16'($urandom));
            run_image($sformatf("rand%0d", t), n, (t == 3) ? (img_sum(n) ^ 16'h0001) : img_sum(n), 2);
        end

`ifdef HACK_BOOT_CHECKSUM_EN
        img = '{16'h8000, 16'h8001};
        run_image("ck_good", 2, 16'h0001, 0);
        run_image("ck_bad", 2, 16'h0002, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
